fb_port_arbiter: RTL and testbench

//  Shares one single-port synchronous framebuffer RAM between the VGA display read path and a camera write path.

---
 rtl/fb_port_arbiter_if.sv | 33 +++
 rtl/fb_port_arbiter.sv | 109 ++++++++++
 tb/tb_fb_port_arbiter.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/fb_port_arbiter_if.sv
// Bundles the arbiter's signals to the timing generator, the camera, the framebuffer RAM and its status.
// slave is the arbiter's view; master is the view of whatever drives it.
interface fb_port_arbiter_if #(
  parameter int ADDR_W  = 19,
  parameter int DATA_W  = 8,
  parameter int FIFO_AW = 4
);
  logic [9:0]        x_pixel;
  logic [9:0]        y_pixel;
  logic              cam_wr_en;
  logic [ADDR_W-1:0] cam_wr_addr;
  logic [DATA_W-1:0] cam_wr_data;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] pix_data;
  logic              pix_valid;
  logic [FIFO_AW:0]  fifo_level;
  logic              fifo_full;
  logic              ovf_sticky;
  logic              ovf_clr;

  modport slave (
    input  x_pixel, y_pixel, cam_wr_en, cam_wr_addr, cam_wr_data, ram_rdata, ovf_clr,
    output ram_addr, ram_we, ram_wdata, pix_data, pix_valid, fifo_level, fifo_full, ovf_sticky
  );

  modport master (
    output x_pixel, y_pixel, cam_wr_en, cam_wr_addr, cam_wr_data, ram_rdata, ovf_clr,
    input  ram_addr, ram_we, ram_wdata, pix_data, pix_valid, fifo_level, fifo_full, ovf_sticky
  );
endinterface

// File: rtl/fb_port_arbiter.sv
// Shares a single-port framebuffer RAM: display reads own the active window, queued camera writes drain in blanking.
// Define FB_ARB_DROP_CNT_EN to add the saturating drop_cnt output.
module fb_port_arbiter #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 19,
  parameter int FIFO_AW  = 4
) (
  input  logic              vga_clk,
  input  logic              rst_n,
  fb_port_arbiter_if.slave  bus
`ifdef FB_ARB_DROP_CNT_EN
  ,
  output logic [15:0]       drop_cnt
`endif
);

  localparam int               DEPTH    = 2 ** FIFO_AW;
  localparam logic [9:0]       H_LIM    = 10'(H_ACTIVE);
  localparam logic [9:0]       V_LIM    = 10'(V_ACTIVE);
  localparam logic [ADDR_W:0]  FB_WORDS = (ADDR_W + 1)'(H_ACTIVE * V_ACTIVE);
  localparam logic [FIFO_AW:0] LVL_FULL = (FIFO_AW + 1)'(DEPTH);

  logic               disp_req;
  logic               wr_ok;
  logic               push;
  logic               pop;
  logic               drop;
  logic [ADDR_W-1:0]  rd_cnt;
  logic [ADDR_W-1:0]  q_addr [DEPTH];
  logic [DATA_W-1:0]  q_data [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic               rd_d1;
  logic               rd_d2;

  assign disp_req      = (bus.x_pixel < H_LIM) && (bus.y_pixel < V_LIM);
  assign bus.fifo_full = (bus.fifo_level == LVL_FULL);
  assign wr_ok         = bus.cam_wr_en && ({1'b0, bus.cam_wr_addr} < FB_WORDS);
  // Fullness is judged on the level at the start of the cycle, so a same-cycle pop never makes room.
  assign push          = wr_ok && !bus.fifo_full;
  assign drop          = wr_ok && bus.fifo_full;
  assign pop           = !disp_req && (bus.fifo_level != '0);

  always_ff @(posedge vga_clk) begin
    if (push) begin
      q_addr[wr_ptr] <= bus.cam_wr_addr;
      q_data[wr_ptr] <= bus.cam_wr_data;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (!rst_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      bus.fifo_level <= '0;
      bus.ovf_sticky <= 1'b0;
      rd_cnt         <= '0;
      bus.ram_addr   <= '0;
      bus.ram_we     <= 1'b0;
      bus.ram_wdata  <= '0;
      rd_d1          <= 1'b0;
      rd_d2          <= 1'b0;
      bus.pix_valid  <= 1'b0;
      bus.pix_data   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   bus.fifo_level <= bus.fifo_level + 1'b1;
        2'b01:   bus.fifo_level <= bus.fifo_level - 1'b1;
        default: bus.fifo_level <= bus.fifo_level;
      endcase

      if (drop)             bus.ovf_sticky <= 1'b1;
      else if (bus.ovf_clr) bus.ovf_sticky <= 1'b0;

      // Vertical blanking parks the scan address so every frame starts at 0.
      if (bus.y_pixel >= V_LIM) rd_cnt <= '0;
      else if (disp_req)        rd_cnt <= rd_cnt + ADDR_W'(1);

      if (disp_req) begin
        bus.ram_addr <= rd_cnt;
        bus.ram_we   <= 1'b0;
      end else if (pop) begin
        bus.ram_addr  <= q_addr[rd_ptr];
        bus.ram_wdata <= q_data[rd_ptr];
        bus.ram_we    <= 1'b1;
      end else begin
        bus.ram_we <= 1'b0;
      end

      rd_d1         <= disp_req;
      rd_d2         <= rd_d1;
      bus.pix_valid <= rd_d2;
      bus.pix_data  <= rd_d2 ? bus.ram_rdata : '0;
    end
  end

`ifdef FB_ARB_DROP_CNT_EN
  always_ff @(posedge vga_clk) begin
    if (!rst_n)                           drop_cnt <= '0;
    else if (bus.ovf_clr)                 drop_cnt <= drop ? 16'd1 : 16'd0;
    else if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed and randomized bench for fb_port_arbiter against a queue-based reference model.
// Checks drop_cnt as well when FB_ARB_DROP_CNT_EN is defined.
module tb_fb_port_arbiter;
  localparam int H = 640, V = 480, AW = 19, DW = 8, FAW = 4;
  localparam int DEPTH = 16, FB = H * V;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic vga_clk = 1'b0;
  logic rst_n   = 1'b0;
  always #5 vga_clk = ~vga_clk;

  fb_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .FIFO_AW(FAW)) bus ();
`ifdef FB_ARB_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  fb_port_arbiter #(.H_ACTIVE(H), .V_ACTIVE(V), .DATA_W(DW), .ADDR_W(AW), .FIFO_AW(FAW)) dut (
    .vga_clk (vga_clk),
    .rst_n   (rst_n),
    .bus     (bus)
`ifdef FB_ARB_DROP_CNT_EN
    ,
    .drop_cnt(drop_cnt)
`endif
  );

  int tests = 0;
  int fails = 0;

  // reference model state
  wr_t           q[$];
  int            m_cnt;
  logic [AW-1:0] e_addr;
  logic          e_we;
  logic [DW-1:0] e_wdata;
  logic          sv[3];
  logic [DW-1:0] sd[3];
  logic          m_ovf;
  int            m_dcnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    bit  disp, drop;
    int  lvl;
    wr_t e;
    if (!rst_n) begin
      q.delete();
      m_cnt = 0; e_addr = '0; e_we = 1'b0; e_wdata = '0;
      for (int i = 0; i < 3; i++) begin sv[i] = 1'b0; sd[i] = '0; end
      m_ovf = 1'b0; m_dcnt = 0;
      return;
    end
    disp = (int'(bus.x_pixel) < H) && (int'(bus.y_pixel) < V);
    lvl  = q.size();
    sv[2] = sv[1]; sd[2] = sd[1];
    sv[1] = sv[0]; sd[1] = sd[0];
    sv[0] = disp;  sd[0] = disp ? DW'(m_cnt) : '0;
    if (disp) begin
      e_addr = AW'(m_cnt); e_we = 1'b0;
    end else if (lvl > 0) begin
      e = q.pop_front();
      e_addr = e.a; e_wdata = e.d; e_we = 1'b1;
    end else begin
      e_we = 1'b0;
    end
    drop = 0;
    if (bus.cam_wr_en && int'(bus.cam_wr_addr) < FB) begin
      if (lvl < DEPTH) q.push_back(wr_t'{a: bus.cam_wr_addr, d: bus.cam_wr_data});
      else drop = 1;
    end
    if (drop) m_ovf = 1'b1;
    else if (bus.ovf_clr) m_ovf = 1'b0;
    if (bus.ovf_clr) m_dcnt = drop ? 1 : 0;
    else if (drop && m_dcnt < 65535) m_dcnt++;
    if (int'(bus.y_pixel) >= V) m_cnt = 0;
    else if (disp) m_cnt++;
  endtask

  task automatic check_all();
    chk("ram_we", 32'(bus.ram_we), 32'(e_we));
    chk("ram_addr", 32'(bus.ram_addr), 32'(e_addr));
    if (e_we) chk("ram_wdata", 32'(bus.ram_wdata), 32'(e_wdata));
    chk("pix_valid", 32'(bus.pix_valid), 32'(sv[2]));
    chk("pix_data", 32'(bus.pix_data), 32'(sd[2]));
    chk("fifo_level", 32'(bus.fifo_level), 32'(q.size()));
    chk("fifo_full", 32'(bus.fifo_full), 32'(q.size() == DEPTH));
    chk("ovf_sticky", 32'(bus.ovf_sticky), 32'(m_ovf));
`ifdef FB_ARB_DROP_CNT_EN
    chk("drop_cnt", 32'(drop_cnt), 32'(m_dcnt));
`endif
  endtask

  // RAM echoes the low address byte one cycle after the address is presented.
  task automatic step();
    logic [DW-1:0] rd_next;
    rd_next = bus.ram_addr[DW-1:0];
    @(posedge vga_clk);
    model_update();
    #1 bus.ram_rdata = rd_next;
    @(negedge vga_clk);
    check_all();
  endtask

  task automatic drive(input int x, input int y, input bit en, input int addr, input int data, input bit clr);
    bus.x_pixel     = 10'(x);
    bus.y_pixel     = 10'(y);
    bus.cam_wr_en   = en;
    bus.cam_wr_addr = AW'(addr);
    bus.cam_wr_data = DW'(data);
    bus.ovf_clr     = clr;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ram_rdata = '0;
    // reset with a live camera strobe
    rst_n = 1'b0;
    drive(0, 0, 1, 3, 8'h33, 0);
    repeat (5) step();
    rst_n = 1'b1;

    // first three pixels of a frame
    drive(0, 0, 0, 0, 0, 0); step();
    drive(1, 0, 0, 0, 0, 0); step();
    drive(2, 0, 0, 0, 0, 0); step();
    drive(700, 0, 0, 0, 0, 0); repeat (4) step();

    // writes queued during active video drain at the start of hblank
    drive(100, 10, 1, 5, 8'hA5, 0); step();
    drive(100, 10, 1, 6, 8'hA6, 0); step();
    drive(100, 10, 1, 7, 8'hA7, 0); step();
    drive(101, 10, 0, 0, 0, 0); repeat (3) step();
    for (int x = 640; x < 645; x++) begin drive(x, 10, 0, 0, 0, 0); step(); end

    // overflow, then clear
    for (int i = 0; i < 17; i++) begin drive(200, 20, 1, 1000 + i, i, 0); step(); end
    drive(201, 20, 0, 0, 0, 1); step();
    drive(202, 20, 0, 0, 0, 0); step();
    // out-of-range write while full is neither queued nor an overflow
    drive(203, 20, 1, FB, 8'h11, 0); step();
    // overflow and clear in the same cycle: the set wins
    drive(204, 20, 1, 2000, 8'h22, 1); step();
    drive(700, 20, 0, 0, 0, 1); repeat (18) step();

    // out-of-range write on an empty FIFO
    drive(300, 30, 1, FB, 8'h44, 0); step();
    drive(700, 30, 1, FB + 5, 8'h45, 0); repeat (3) step();

    // frame wrap through vblank
    drive(639, 479, 0, 0, 0, 0); step();
    drive(700, 479, 0, 0, 0, 0); step();
    drive(0, 490, 0, 0, 0, 0); repeat (3) step();
    drive(0, 0, 0, 0, 0, 0); step();
    drive(1, 0, 0, 0, 0, 0); step();
    drive(700, 0, 0, 0, 0, 0); repeat (4) step();

    // reset mid-frame discards queued writes
    for (int i = 0; i < 3; i++) begin drive(50 + i, 5, 1, 40 + i, 8'h50 + i, 0); step(); end
    rst_n = 1'b0; drive(53, 5, 0, 0, 0, 0); step();
    rst_n = 1'b1; drive(700, 5, 0, 0, 0, 0); repeat (4) step();

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      int x, y, addr;
      x    = ($urandom_range(0, 99) < 85) ? $urandom_range(0, 639) : $urandom_range(640, 799);
      y    = ($urandom_range(0, 19) == 0) ? $urandom_range(480, 524) : $urandom_range(0, 479);
      addr = ($urandom_range(0, 15) == 0) ? FB + $urandom_range(0, 1000) : $urandom_range(0, FB - 1);
      drive(x, y, $urandom_range(0, 2) != 0, addr, $urandom_range(0, 255), $urandom_range(0, 24) == 0);
      step();
    end
    drive(700, 500, 0, 0, 0, 0); repeat (20) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
